// File: rtl/wb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// wb_i2c_master_ctrl
//   Single-beat Wishbone classic master. Converts a level-sampled read or
//   write request from a local control FSM into one Wishbone bus cycle
//   aimed at the register file of an I2C master core. Reports completion,
//   read data and an optional ack-timeout error back to the caller.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   o_wbs_adr/dat/we/stb/cyc, i_wbs_dat/ack
//                          Wishbone master side (to the I2C core's slave port)
//   i_ren, i_wren          read / write request (write wins when both high)
//   i_addr, i_data         register address / write data, sampled with request
//   o_data                 last read data, held between reads
//   o_data_val             one-cycle pulse, o_data updated (reads only)
//   o_done                 one-cycle pulse, transaction finished
//   o_err                  one-cycle pulse alongside o_done on ack timeout
// ---------------------------------------------------------------------------
module wb_i2c_master_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 0   // 0 = wait for ack forever
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_wbs_adr,
  output logic [DATA_WIDTH-1:0] o_wbs_dat,
  input  logic [DATA_WIDTH-1:0] i_wbs_dat,
  output logic                  o_wbs_we,
  output logic                  o_wbs_stb,
  input  logic                  i_wbs_ack,
  output logic                  o_wbs_cyc,
  input  logic                  i_ren,
  input  logic                  i_wren,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_val,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Counter only needs to reach ACK_TIMEOUT-1; keep at least one bit so the
  // timeout-disabled build still elaborates cleanly.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_d;
  logic [DATA_WIDTH-1:0]   dat_d, data_d;
  logic                    we_d, stb_d, cyc_d;
  logic                    val_d, done_d, err_d;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = o_wbs_adr;
    dat_d   = o_wbs_dat;
    we_d    = o_wbs_we;
    stb_d   = o_wbs_stb;
    cyc_d   = o_wbs_cyc;
    data_d  = o_data;
    val_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Spurious acks are ignored here simply by not looking at i_wbs_ack.
        if (i_wren) begin
          adr_d   = i_addr;
          dat_d   = i_data;
          we_d    = 1'b1;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end else if (i_ren) begin
          adr_d   = i_addr;
          we_d    = 1'b0;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Bus signals hold their registered values until ack or timeout;
        // new requests are not looked at here.
        if (i_wbs_ack) begin
          we_d    = 1'b0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!o_wbs_we) begin
            data_d = i_wbs_dat;
            val_d  = 1'b1;
          end
          state_d = IDLE;
        end else if (ACK_TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          we_d    = 1'b0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ACK_TIMEOUT > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o_wbs_adr  <= '0;
      o_wbs_dat  <= '0;
      o_wbs_we   <= 1'b0;
      o_wbs_stb  <= 1'b0;
      o_wbs_cyc  <= 1'b0;
      o_data     <= '0;
      o_data_val <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_wbs_adr  <= adr_d;
      o_wbs_dat  <= dat_d;
      o_wbs_we   <= we_d;
      o_wbs_stb  <= stb_d;
      o_wbs_cyc  <= cyc_d;
      o_data     <= data_d;
      o_data_val <= val_d;
      o_done     <= done_d;
      o_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_i2c_master_ctrl
//   Directed plus randomized bench. The bench plays the Wishbone slave and
//   the requesting FSM. Expected values come from a transaction-level view:
//   what the bus must show while a request is outstanding, and the last
//   read value the caller should hold. Two instances share all inputs; one
//   has an 8-cycle ack timeout, the other waits forever.
// ---------------------------------------------------------------------------
module tb_wb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [2:0] i_addr;
  logic [7:0] i_data;
  logic       i_ren, i_wren;
  logic [7:0] i_wbs_dat;
  logic       i_wbs_ack;

  logic [2:0] o_wbs_adr;
  logic [7:0] o_wbs_dat, o_data;
  logic       o_wbs_we, o_wbs_stb, o_wbs_cyc, o_data_val, o_done, o_err;

  logic [2:0] z_wbs_adr;
  logic [7:0] z_wbs_dat, z_data;
  logic       z_wbs_we, z_wbs_stb, z_wbs_cyc, z_data_val, z_done, z_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] model_data;   // last value the caller should see on o_data

  always #5 clk = ~clk;

  wb_i2c_master_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .ACK_TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_wbs_adr(o_wbs_adr), .o_wbs_dat(o_wbs_dat), .i_wbs_dat(i_wbs_dat),
    .o_wbs_we(o_wbs_we), .o_wbs_stb(o_wbs_stb), .i_wbs_ack(i_wbs_ack),
    .o_wbs_cyc(o_wbs_cyc), .i_ren(i_ren), .i_wren(i_wren),
    .i_data(i_data), .i_addr(i_addr), .o_data(o_data),
    .o_data_val(o_data_val), .o_done(o_done), .o_err(o_err)
  );

  wb_i2c_master_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .ACK_TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_reset(i_reset),
    .o_wbs_adr(z_wbs_adr), .o_wbs_dat(z_wbs_dat), .i_wbs_dat(i_wbs_dat),
    .o_wbs_we(z_wbs_we), .o_wbs_stb(z_wbs_stb), .i_wbs_ack(i_wbs_ack),
    .o_wbs_cyc(z_wbs_cyc), .i_ren(i_ren), .i_wren(i_wren),
    .i_data(i_data), .i_addr(i_addr), .o_data(z_data),
    .o_data_val(z_data_val), .o_done(z_done), .o_err(z_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle: no bus activity and no pulses.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_cyc"},  32'(o_wbs_cyc),  0);
    check({tag, "_done"}, 32'(o_done),     0);
    check({tag, "_val"},  32'(o_data_val), 0);
    check({tag, "_err"},  32'(o_err),      0);
  endtask

  // One complete transaction. Called and returns at a negedge.
  //   wr    : write (else read); both : raise both requests (write expected)
  //   hold  : leave the request asserted on return
  //   poke  : fire a stray write request during the first wait cycle
  //   wait_n: slave wait states before ack
  task automatic txn(input bit wr, input bit both, input bit hold, input bit poke,
                     input logic [2:0] addr, input logic [7:0] wdata,
                     input int wait_n, input logic [7:0] rdata);
    bit is_wr;
    is_wr  = wr || both;
    i_addr = addr;
    i_data = wdata;
    i_wren = wr || both;
    i_ren  = !wr || both;
    @(negedge clk);
    if (!hold) begin
      i_wren = 1'b0;
      i_ren  = 1'b0;
    end
    check("bus_cyc",  32'(o_wbs_cyc), 1);
    check("bus_stb",  32'(o_wbs_stb), 1);
    check("bus_we",   32'(o_wbs_we),  32'(is_wr));
    check("bus_adr",  32'(o_wbs_adr), 32'(addr));
    if (is_wr) check("bus_dat", 32'(o_wbs_dat), 32'(wdata));
    check("bus_done", 32'(o_done), 0);
    for (int w = 0; w < wait_n; w++) begin
      if (poke) begin
        i_wren = (w == 0);
        i_addr = ~addr;
        i_data = ~wdata;
      end
      @(negedge clk);
      check("wait_cyc",  32'(o_wbs_cyc), 1);
      check("wait_stb",  32'(o_wbs_stb), 1);
      check("wait_adr",  32'(o_wbs_adr), 32'(addr));
      check("wait_done", 32'(o_done),    0);
      if (is_wr) check("wait_dat", 32'(o_wbs_dat), 32'(wdata));
    end
    if (poke) begin
      i_wren = 1'b0;
      i_addr = addr;
    end
    i_wbs_ack = 1'b1;
    i_wbs_dat = rdata;
    @(negedge clk);
    i_wbs_ack = 1'b0;
    i_wbs_dat = 8'($urandom);
    if (!is_wr) model_data = rdata;
    check("done_cyc",  32'(o_wbs_cyc),  0);
    check("done_stb",  32'(o_wbs_stb),  0);
    check("done_pls",  32'(o_done),     1);
    check("done_val",  32'(o_data_val), 32'(!is_wr));
    check("done_err",  32'(o_err),      0);
    check("done_data", 32'(o_data),     32'(model_data));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_data = 8'h00;
    i_reset    = 1'b1;
    i_wren     = 1'b1;
    i_ren      = 1'b0;
    i_addr     = 3'd5;
    i_data     = 8'h33;
    i_wbs_ack  = 1'b0;
    i_wbs_dat  = 8'h00;

    // Reset held with a write pending: nothing may move.
    repeat (3) begin
      @(negedge clk);
      check("rst_cyc",  32'(o_wbs_cyc),  0);
      check("rst_stb",  32'(o_wbs_stb),  0);
      check("rst_we",   32'(o_wbs_we),   0);
      check("rst_adr",  32'(o_wbs_adr),  0);
      check("rst_dat",  32'(o_wbs_dat),  0);
      check("rst_data", 32'(o_data),     0);
      check("rst_pls",  32'({o_data_val, o_done, o_err}), 0);
    end
    // Release: the still-high write starts on the next edge.
    i_reset = 1'b0;
    @(negedge clk);
    i_wren = 1'b0;
    check("rel_cyc", 32'(o_wbs_cyc), 1);
    check("rel_we",  32'(o_wbs_we),  1);
    check("rel_adr", 32'(o_wbs_adr), 5);
    check("rel_dat", 32'(o_wbs_dat), 32'h33);
    i_wbs_ack = 1'b1;
    @(negedge clk);
    i_wbs_ack = 1'b0;
    check("rel_done", 32'(o_done),     1);
    check("rel_val",  32'(o_data_val), 0);
    idle_check("rel_idle");

    // Write with one wait state, then read with three.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h80, 1, 8'h00);
    idle_check("wr_idle");
    txn(1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 8'h00, 3, 8'h02);
    idle_check("rd_idle");

    // Held read polling: three back-to-back bus cycles.
    txn(1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'h00, 0, 8'h02);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'h00, 2, 8'h02);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'h00, 1, 8'h00);
    i_ren = 1'b0;
    idle_check("poll_idle");

    // Both requests high -> write; stray write while busy is ignored.
    txn(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 8'h5A, 3, 8'hEE);
    idle_check("busy_idle");
    idle_check("busy_idle2");

    // Spurious ack in IDLE.
    i_wbs_ack = 1'b1;
    i_wbs_dat = 8'hA5;
    @(negedge clk);
    i_wbs_ack = 1'b0;
    check("spur_cyc",  32'(o_wbs_cyc), 0);
    check("spur_pls",  32'({o_data_val, o_done, o_err}), 0);
    check("spur_data", 32'(o_data), 32'(model_data));

    // Reset mid-transaction: abort with no done pulse, o_data cleared.
    i_ren  = 1'b1;
    i_addr = 3'd1;
    @(negedge clk);
    i_ren = 1'b0;
    check("abort_busy", 32'(o_wbs_cyc), 1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset    = 1'b0;
    model_data = 8'h00;
    check("abort_cyc",  32'(o_wbs_cyc), 0);
    check("abort_pls",  32'({o_data_val, o_done, o_err}), 0);
    check("abort_data", 32'(o_data), 0);
    idle_check("abort_idle");

    // Randomized transactions, wait states kept below the timeout.
    for (int n = 0; n < 24; n++) begin
      txn(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 3'($urandom), 8'($urandom),
          int'($urandom_range(0, 5)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check("rnd_idle");
    end
    idle_check("rnd_end");

    // Timeout: slave never acks. Bus stays up for exactly 8 cycles.
    i_ren  = 1'b1;
    i_addr = 3'd6;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      i_ren = 1'b0;
      check("to_busy", 32'(o_wbs_cyc), 1);
      check("to_done", 32'(o_done),    0);
    end
    @(negedge clk);
    check("to_cyc",  32'(o_wbs_cyc),  0);
    check("to_stb",  32'(o_wbs_stb),  0);
    check("to_pls",  32'(o_done),     1);
    check("to_err",  32'(o_err),      1);
    check("to_val",  32'(o_data_val), 0);
    check("to_data", 32'(o_data),     32'(model_data));
    idle_check("to_idle");

    // The no-timeout instance is still waiting.
    repeat (20) @(negedge clk);
    check("nt_cyc",  32'(z_wbs_cyc), 1);
    check("nt_stb",  32'(z_wbs_stb), 1);
    check("nt_adr",  32'(z_wbs_adr), 6);
    check("nt_pls",  32'({z_data_val, z_done, z_err}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
